// File: rtl/alu_uart_sequencer_if.sv
// -----------------------------------------------------------------------------
// alu_uart_sequencer_if
// Groups the byte-stream and ALU handshake signals of alu_uart_sequencer.
//   i_rx_data/i_rx_done  : byte from uart_rx, valid on the one-cycle done pulse
//   i_tx_done            : uart_tx finished the current byte
//   i_alu_result/ready   : ALU result and its valid flag
//   o_op_a/o_op_b/o_opcode/o_alu_start : registered ALU operands and start
//   o_tx_data/o_tx_start : byte and start pulse for uart_tx
//   o_busy/o_frame_error/o_rx_overrun  : status
// Modports: slave = the sequencer, master = its environment.
// -----------------------------------------------------------------------------
interface alu_uart_sequencer_if #(
  parameter int DATA_SIZE   = 8,
  parameter int OPCODE_SIZE = 6
);
  logic [DATA_SIZE-1:0]   i_rx_data;
  logic                   i_rx_done;
  logic                   i_tx_done;
  logic [DATA_SIZE-1:0]   i_alu_result;
  logic                   i_alu_ready;
  logic [DATA_SIZE-1:0]   o_op_a;
  logic [DATA_SIZE-1:0]   o_op_b;
  logic [OPCODE_SIZE-1:0] o_opcode;
  logic                   o_alu_start;
  logic [DATA_SIZE-1:0]   o_tx_data;
  logic                   o_tx_start;
  logic                   o_busy;
  logic                   o_frame_error;
  logic                   o_rx_overrun;

  modport slave (
    input  i_rx_data, i_rx_done, i_tx_done, i_alu_result, i_alu_ready,
    output o_op_a, o_op_b, o_opcode, o_alu_start, o_tx_data, o_tx_start,
           o_busy, o_frame_error, o_rx_overrun
  );

  modport master (
    output i_rx_data, i_rx_done, i_tx_done, i_alu_result, i_alu_ready,
    input  o_op_a, o_op_b, o_opcode, o_alu_start, o_tx_data, o_tx_start,
           o_busy, o_frame_error, o_rx_overrun
  );
endinterface

// File: rtl/alu_uart_sequencer.sv
// -----------------------------------------------------------------------------
// alu_uart_sequencer
// Collects a 3-byte UART frame (operand A, operand B, opcode), runs the shared
// ALU, and sends the result byte back through uart_tx.
// Ports:
//   i_clk   : system clock
//   i_reset : asynchronous active-low reset
//   bus     : alu_uart_sequencer_if.slave (RX/TX/ALU handshakes and status)
// Parameters: DATA_SIZE, OPCODE_SIZE, TIMEOUT_CYCLES (0 = no inter-byte timeout)
// Optional feature macro: ALU_SEQ_STATUS_EN -- appends a status byte
//   {opcode_unsupported, frame_count[6:0]} after every result byte.
// -----------------------------------------------------------------------------
module alu_uart_sequencer #(
  parameter int DATA_SIZE      = 8,
  parameter int OPCODE_SIZE    = 6,
  parameter int TIMEOUT_CYCLES = 100000
) (
  input logic                 i_clk,
  input logic                 i_reset,
  alu_uart_sequencer_if.slave bus
);

  localparam int TO_W    = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam int TO_LAST = (TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0;
  localparam logic [TO_W-1:0] TO_LAST_V = TO_W'(TO_LAST);

  typedef enum logic [2:0] {
    ST_GET_A,
    ST_GET_B,
    ST_GET_OP,
    ST_EXEC,
    ST_SEND,
    ST_WAIT_TX
`ifdef ALU_SEQ_STATUS_EN
    ,
    ST_SEND_ST,
    ST_WAIT_ST
`endif
  } state_t;

  state_t                 r_state;
  logic [TO_W-1:0]        r_to_cnt;
  logic [DATA_SIZE-1:0]   r_op_a;
  logic [DATA_SIZE-1:0]   r_op_b;
  logic [OPCODE_SIZE-1:0] r_opcode;
  logic                   r_alu_start;
  logic [DATA_SIZE-1:0]   r_tx_data;
  logic                   r_tx_start;
  logic                   r_busy;
  logic                   r_frame_error;
  logic                   r_rx_overrun;

  logic w_timeout;
  logic w_busy_state;

  // Expiry only exists when a timeout is configured.
  assign w_timeout    = (TIMEOUT_CYCLES != 0) && (r_to_cnt == TO_LAST_V);
  assign w_busy_state = !(r_state inside {ST_GET_A, ST_GET_B, ST_GET_OP});

`ifdef ALU_SEQ_STATUS_EN
  logic [6:0]  r_frame_cnt;
  logic [6:0]  w_frame_cnt_nxt;
  logic [31:0] w_opcode_ext;
  logic        w_op_bad;
  logic [7:0]  w_status;

  assign w_frame_cnt_nxt = r_frame_cnt + 7'd1;
  assign w_opcode_ext    = 32'(r_opcode);
  assign w_op_bad        = !(w_opcode_ext inside {32'h20, 32'h22, 32'h24, 32'h25,
                                                  32'h26, 32'h27, 32'h28, 32'h29});
  assign w_status        = {w_op_bad, w_frame_cnt_nxt};
`endif

  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      r_state       <= ST_GET_A;
      r_to_cnt      <= '0;
      r_op_a        <= '0;
      r_op_b        <= '0;
      r_opcode      <= '0;
      r_alu_start   <= 1'b0;
      r_tx_data     <= '0;
      r_tx_start    <= 1'b0;
      r_busy        <= 1'b0;
      r_frame_error <= 1'b0;
      r_rx_overrun  <= 1'b0;
`ifdef ALU_SEQ_STATUS_EN
      r_frame_cnt   <= '0;
`endif
    end else begin
      r_tx_start    <= 1'b0;
      r_frame_error <= 1'b0;
      // Bytes arriving while the frame is being processed are dropped.
      r_rx_overrun  <= bus.i_rx_done && w_busy_state;

      case (r_state)
        ST_GET_A: begin
          r_to_cnt <= '0;
          if (bus.i_rx_done) begin
            r_op_a  <= bus.i_rx_data;
            r_state <= ST_GET_B;
          end
        end

        // An accepted byte takes priority over a coincident expiry.
        ST_GET_B: begin
          if (bus.i_rx_done) begin
            r_op_b   <= bus.i_rx_data;
            r_to_cnt <= '0;
            r_state  <= ST_GET_OP;
          end else if (w_timeout) begin
            r_frame_error <= 1'b1;
            r_to_cnt      <= '0;
            r_state       <= ST_GET_A;
          end else if (TIMEOUT_CYCLES != 0) begin
            r_to_cnt <= r_to_cnt + 1'b1;
          end
        end

        ST_GET_OP: begin
          if (bus.i_rx_done) begin
            r_opcode    <= bus.i_rx_data[OPCODE_SIZE-1:0];
            r_to_cnt    <= '0;
            r_alu_start <= 1'b1;
            r_busy      <= 1'b1;
            r_state     <= ST_EXEC;
          end else if (w_timeout) begin
            r_frame_error <= 1'b1;
            r_to_cnt      <= '0;
            r_state       <= ST_GET_A;
          end else if (TIMEOUT_CYCLES != 0) begin
            r_to_cnt <= r_to_cnt + 1'b1;
          end
        end

        ST_EXEC: begin
          if (bus.i_alu_ready) begin
            r_tx_data   <= bus.i_alu_result;
            r_tx_start  <= 1'b1;
            r_alu_start <= 1'b0;
            r_state     <= ST_SEND;
          end
        end

        ST_SEND: r_state <= ST_WAIT_TX;

        ST_WAIT_TX: begin
          if (bus.i_tx_done) begin
`ifdef ALU_SEQ_STATUS_EN
            r_frame_cnt <= w_frame_cnt_nxt;
            r_tx_data   <= DATA_SIZE'(w_status);
            r_tx_start  <= 1'b1;
            r_state     <= ST_SEND_ST;
`else
            r_busy  <= 1'b0;
            r_state <= ST_GET_A;
`endif
          end
        end

`ifdef ALU_SEQ_STATUS_EN
        ST_SEND_ST: r_state <= ST_WAIT_ST;

        ST_WAIT_ST: begin
          if (bus.i_tx_done) begin
            r_busy  <= 1'b0;
            r_state <= ST_GET_A;
          end
        end
`endif

        default: r_state <= ST_GET_A;
      endcase
    end
  end

  assign bus.o_op_a        = r_op_a;
  assign bus.o_op_b        = r_op_b;
  assign bus.o_opcode      = r_opcode;
  assign bus.o_alu_start   = r_alu_start;
  assign bus.o_tx_data     = r_tx_data;
  assign bus.o_tx_start    = r_tx_start;
  assign bus.o_busy        = r_busy;
  assign bus.o_frame_error = r_frame_error;
  assign bus.o_rx_overrun  = r_rx_overrun;

endmodule
